// File: rtl/i2c_axil_test_seq.sv
// Programmable AXI-lite master sequencer for bring-up of an AXI-lite register slave.
// Define I2C_AXIL_SEQ_RESP_CHECK_EN to count non-OKAY bresp/rresp beats as errors.
module i2c_axil_test_seq #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OPS    = 16,
    parameter int POLL_MAX   = 1024,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [7:0]                           loops,
    input  logic                                 op_we,
    input  logic [$clog2(NUM_OPS)-1:0]           op_waddr,
    input  logic [2+ADDR_WIDTH+2*DATA_WIDTH-1:0] op_wdata,
    input  logic [$clog2(NUM_OPS):0]             op_count,
    output logic [ADDR_WIDTH-1:0]                m_axil_awaddr,
    output logic [2:0]                           m_axil_awprot,
    output logic                                 m_axil_awvalid,
    input  logic                                 m_axil_awready,
    output logic [DATA_WIDTH-1:0]                m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]              m_axil_wstrb,
    output logic                                 m_axil_wvalid,
    input  logic                                 m_axil_wready,
    input  logic [1:0]                           m_axil_bresp,
    input  logic                                 m_axil_bvalid,
    output logic                                 m_axil_bready,
    output logic [ADDR_WIDTH-1:0]                m_axil_araddr,
    output logic [2:0]                           m_axil_arprot,
    output logic                                 m_axil_arvalid,
    input  logic                                 m_axil_arready,
    input  logic [DATA_WIDTH-1:0]                m_axil_rdata,
    input  logic [1:0]                           m_axil_rresp,
    input  logic                                 m_axil_rvalid,
    output logic                                 m_axil_rready,
    output logic                                 busy,
    output logic                                 done,
    output logic [ERR_WIDTH-1:0]                 err_count,
    output logic                                 timeout,
    output logic [DATA_WIDTH-1:0]                last_rdata
);

    localparam int IDX_W = $clog2(NUM_OPS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OP_W  = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam logic [ATT_W-1:0] POLL_LIM = ATT_W'(POLL_MAX);

`ifdef I2C_AXIL_SEQ_RESP_CHECK_EN
    localparam bit RESP_CHECK = 1'b1;
`else
    localparam bit RESP_CHECK = 1'b0;
`endif

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WR_ADDR_DATA, S_WR_RESP,
        S_RD_ADDR, S_RD_DATA, S_CHECK, S_NEXT, S_DONE
    } state_t;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (v == '1) ? v : v + ERR_WIDTH'(1);
    endfunction

    function automatic logic resp_err(input logic [1:0] resp);
        return RESP_CHECK && (resp != 2'b00);
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             pass_q, pass_d;
    logic [7:0]             loops_q, loops_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [ATT_W-1:0]       attempts_q, attempts_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic                   timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0]  last_rdata_q, last_rdata_d;

    logic [OP_W-1:0]        op_mem [NUM_OPS];
    logic [OP_W-1:0]        op_q;

    logic [1:0]             op_type;
    logic [ADDR_WIDTH-1:0]  op_addr;
    logic [DATA_WIDTH-1:0]  op_data;
    logic [DATA_WIDTH-1:0]  op_mask;
    logic                   mismatch;
    logic                   last_op;
    logic                   last_pass;

    assign op_type   = op_q[OP_W-1 -: 2];
    assign op_addr   = op_q[2*DATA_WIDTH +: ADDR_WIDTH];
    assign op_data   = op_q[DATA_WIDTH +: DATA_WIDTH];
    assign op_mask   = op_q[0 +: DATA_WIDTH];
    assign mismatch  = |((last_rdata_q ^ op_data) & op_mask);
    assign last_op   = ({1'b0, idx_q} == count_q - CNT_W'(1));
    assign last_pass = (pass_q == loops_q - 8'd1);

    // Op memory is loaded only from IDLE; the read port is registered (one-cycle fetch).
    always_ff @(posedge clk) begin
        if (op_we && state_q == S_IDLE) begin
            op_mem[op_waddr] <= op_wdata;
        end
        if (state_q == S_FETCH) begin
            op_q <= op_mem[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pass_q       <= '0;
            loops_q      <= 8'd1;
            count_q      <= CNT_W'(1);
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            attempts_q   <= '0;
            err_q        <= '0;
            timeout_q    <= 1'b0;
            last_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            loops_q      <= loops_d;
            count_q      <= count_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            attempts_q   <= attempts_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            last_rdata_q <= last_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pass_d       = pass_q;
        loops_d      = loops_q;
        count_d      = count_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        attempts_d   = attempts_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        last_rdata_d = last_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    pass_d    = '0;
                    loops_d   = (loops == 8'd0) ? 8'd1 : loops;
                    count_d   = (op_count == '0) ? CNT_W'(1) : op_count;
                    err_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                attempts_d = '0;
                case (op_type)
                    OP_NOP:   state_d = S_NEXT;
                    OP_WRITE: state_d = S_WR_ADDR_DATA;
                    default:  state_d = S_RD_ADDR;
                endcase
            end
            S_WR_ADDR_DATA: begin
                // Each channel is tracked separately so a late ready never re-issues the other.
                aw_done_d = aw_done_q | m_axil_awready;
                w_done_d  = w_done_q | m_axil_wready;
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axil_bvalid) begin
                    if (resp_err(m_axil_bresp)) err_d = sat_inc(err_q);
                    state_d = S_NEXT;
                end
            end
            S_RD_ADDR: if (m_axil_arready) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (m_axil_rvalid) begin
                    last_rdata_d = m_axil_rdata;
                    if (resp_err(m_axil_rresp)) err_d = sat_inc(err_q);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (op_type == OP_READ) begin
                    if (mismatch) err_d = sat_inc(err_q);
                    state_d = S_NEXT;
                end else if (!mismatch) begin
                    state_d = S_NEXT;
                end else if (attempts_q + ATT_W'(1) == POLL_LIM) begin
                    timeout_d = 1'b1;
                    err_d     = sat_inc(err_q);
                    state_d   = S_NEXT;
                end else begin
                    attempts_d = attempts_q + ATT_W'(1);
                    state_d    = S_RD_ADDR;
                end
            end
            S_NEXT: begin
                if (last_op && last_pass) begin
                    state_d = S_DONE;
                end else if (last_op) begin
                    idx_d   = '0;
                    pass_d  = pass_q + 8'd1;
                    state_d = S_FETCH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign m_axil_awaddr  = op_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
    assign m_axil_wdata   = op_data;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
    assign m_axil_bready  = (state_q == S_WR_RESP);
    assign m_axil_araddr  = op_addr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (state_q == S_RD_ADDR);
    assign m_axil_rready  = (state_q == S_RD_DATA);

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err_count  = err_q;
    assign timeout    = timeout_q;
    assign last_rdata = last_rdata_q;

endmodule

// File: tb/tb_i2c_axil_test_seq.sv
// Directed bench for i2c_axil_test_seq with a small AXI-lite slave model and skewable readies.
module tb_i2c_axil_test_seq;
    localparam int AW = 4, DW = 32, NOPS = 4, PMAX = 6, EW = 16;
    localparam int OPW = 2 + AW + 2 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1, start = 1'b0, op_we = 1'b0;
    logic [7:0]     loops = 8'd0;
    logic [1:0]     op_waddr = '0;
    logic [OPW-1:0] op_wdata = '0;
    logic [2:0]     op_count = '0;
    logic [AW-1:0]  awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, wvalid, bready, arvalid, rready;
    logic           awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
    logic [DW-1:0]  wdata, rdata = '0;
    logic [3:0]     wstrb;
    logic [1:0]     bresp = 2'b00, rresp = 2'b00;
    logic           busy, done, timeout;
    logic [EW-1:0]  err_count;
    logic [DW-1:0]  last_rdata;

    i2c_axil_test_seq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OPS(NOPS), .POLL_MAX(PMAX), .ERR_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .loops(loops),
        .op_we(op_we), .op_waddr(op_waddr), .op_wdata(op_wdata), .op_count(op_count),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready), .busy(busy), .done(done), .err_count(err_count),
        .timeout(timeout), .last_rdata(last_rdata)
    );

    int checks = 0, failures = 0;

    // Slave knobs, set only by the stimulus block
    int aw_delay = 0, w_delay = 0;
    int poll_ones = -1, poll_base = 0;
    bit r_hold = 1'b0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    int aw_cnt = 0, w_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [DW-1:0] smem [4];

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready) begin
            w_hs <= w_hs + 1;
            smem[awaddr[3:2]] <= wdata;
        end
        if (bvalid && bready) b_hs <= b_hs + 1;
        if (arvalid && arready) ar_hs <= ar_hs + 1;
        if (rvalid && rready) r_hs <= r_hs + 1;
    end

    // Readies are one-cycle pulses raised only against a live valid.
    always @(negedge clk) begin
        if (rst) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0;
        end else begin
            if (awready) awready = 1'b0;
            else if (awvalid) begin
                if (aw_cnt >= aw_delay) begin awready = 1'b1; aw_cnt = 0; end
                else aw_cnt++;
            end
            if (wready) wready = 1'b0;
            else if (wvalid) begin
                if (w_cnt >= w_delay) begin wready = 1'b1; w_cnt = 0; end
                else w_cnt++;
            end
            if (arready) arready = 1'b0;
            else if (arvalid) arready = 1'b1;
            if (bvalid) begin
                if (!bready) bvalid = 1'b0;
            end else if (bready) begin
                bvalid = 1'b1; bresp = bresp_cfg;
            end
            if (rvalid) begin
                if (!rready) rvalid = 1'b0;
            end else if (rready && !r_hold) begin
                rvalid = 1'b1; rresp = rresp_cfg;
                if (poll_ones >= 0) rdata = ((r_hs - poll_base) < poll_ones) ? 32'd1 : 32'd0;
                else rdata = smem[araddr[3:2]];
            end
        end
    end

    int  b_aw, b_w, b_b, b_ar, b_r;
    bit  ok;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_r = r_hs;
    endtask

    task automatic load_op(input logic [1:0] idx, input logic [1:0] t, input logic [3:0] a,
                           input logic [31:0] d, input logic [31:0] m);
        op_we = 1'b1; op_waddr = idx; op_wdata = {t, a, d, m};
        @(posedge clk); #2;
        op_we = 1'b0;
    endtask

    task automatic start_seq(input logic [2:0] cnt, input logic [7:0] lp);
        op_count = cnt; loops = lp; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(posedge clk); #2;
        end
        check(tag, 64'(ok), 64'h1);
    endtask

    task automatic run_seq(input logic [2:0] cnt, input logic [7:0] lp, input string tag);
        start_seq(cnt, lp);
        wait_done(tag);
        @(posedge clk); #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, busy, done, timeout}), 64'h0);
        check("rst_err", 64'(err_count), 64'h0);
        check("rst_rdata", 64'(last_rdata), 64'h0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Write then read back
        load_op(2'd0, 2'b01, 4'h4, 32'h0000_00A5, 32'h0);
        load_op(2'd1, 2'b10, 4'h4, 32'h0000_00A5, 32'hFF);
        snap();
        start_seq(3'd2, 8'd1);
        check("busy_after_start", 64'(busy), 64'h1);
        wait_done("t1_done");
        check("t1_aw", 64'(aw_hs - b_aw), 64'd1);
        check("t1_w", 64'(w_hs - b_w), 64'd1);
        check("t1_b", 64'(b_hs - b_b), 64'd1);
        check("t1_ar", 64'(ar_hs - b_ar), 64'd1);
        check("t1_r", 64'(r_hs - b_r), 64'd1);
        check("t1_err", 64'(err_count), 64'h0);
        check("t1_rdata", 64'(last_rdata), 64'hA5);
        check("t1_wstrb_prot", 64'({wstrb, awprot, arprot}), 64'h3C0);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("t1_busy_after_done", 64'({busy, done}), 64'h0);
        @(posedge clk); #2;

        // Handshake skew: AW early, W early, then both together
        load_op(2'd0, 2'b01, 4'h8, 32'h1122_3344, 32'h0);
        aw_delay = 0; w_delay = 3; snap();
        run_seq(3'd1, 8'd1, "t2a_done");
        check("t2a_aw", 64'(aw_hs - b_aw), 64'd1);
        check("t2a_w", 64'(w_hs - b_w), 64'd1);
        check("t2a_mem", 64'(smem[2]), 64'h1122_3344);
        load_op(2'd0, 2'b01, 4'h8, 32'h5566_7788, 32'h0);
        aw_delay = 3; w_delay = 0; snap();
        run_seq(3'd1, 8'd1, "t2b_done");
        check("t2b_aw", 64'(aw_hs - b_aw), 64'd1);
        check("t2b_w", 64'(w_hs - b_w), 64'd1);
        check("t2b_mem", 64'(smem[2]), 64'h5566_7788);
        load_op(2'd0, 2'b01, 4'h8, 32'h99AA_BBCC, 32'h0);
        aw_delay = 0; w_delay = 0; snap();
        start_seq(3'd1, 8'd1);
        load_op(2'd0, 2'b01, 4'h8, 32'hDEAD_BEEF, 32'h0);
        wait_done("t2c_done");
        @(posedge clk); #2;
        check("t2c_aw", 64'(aw_hs - b_aw), 64'd1);
        check("t2c_w", 64'(w_hs - b_w), 64'd1);
        snap();
        run_seq(3'd1, 8'd1, "t2d_done");
        check("t2d_busy_we_dropped", 64'(smem[2]), 64'h99AA_BBCC);

        // Poll clears on the last allowed attempt
        load_op(2'd0, 2'b11, 4'h0, 32'h0, 32'h1);
        poll_ones = 5; poll_base = r_hs; snap();
        run_seq(3'd1, 8'd1, "t3_done");
        check("t3_ar", 64'(ar_hs - b_ar), 64'd6);
        check("t3_timeout", 64'(timeout), 64'h0);
        check("t3_err", 64'(err_count), 64'h0);
        check("t3_rdata", 64'(last_rdata), 64'h0);

        // Poll never clears
        poll_ones = 100; poll_base = r_hs; snap();
        run_seq(3'd1, 8'd1, "t4_done");
        check("t4_ar", 64'(ar_hs - b_ar), 64'd6);
        check("t4_timeout", 64'(timeout), 64'h1);
        check("t4_err", 64'(err_count), 64'h1);
        check("t4_rdata", 64'(last_rdata), 64'h1);
        poll_ones = -1;

        // Three passes with a mismatching read
        load_op(2'd0, 2'b01, 4'hC, 32'h5A, 32'h0);
        load_op(2'd1, 2'b10, 4'hC, 32'h5B, 32'hFF);
        snap();
        run_seq(3'd2, 8'd3, "t5_done");
        check("t5_aw", 64'(aw_hs - b_aw), 64'd3);
        check("t5_ar", 64'(ar_hs - b_ar), 64'd3);
        check("t5_err", 64'(err_count), 64'd3);
        check("t5_timeout_cleared", 64'(timeout), 64'h0);
        check("t5_rdata", 64'(last_rdata), 64'h5A);
        snap();
        start_seq(3'd1, 8'd0);
        check("t5_err_cleared", 64'(err_count), 64'h0);
        wait_done("t5b_done");
        @(posedge clk); #2;
        check("t5_loops0_aw", 64'(aw_hs - b_aw), 64'd1);

        // NOP followed by a matching read
        load_op(2'd0, 2'b00, 4'h0, 32'h0, 32'h0);
        load_op(2'd1, 2'b10, 4'hC, 32'h5A, 32'hFF);
        snap();
        run_seq(3'd2, 8'd1, "t6_done");
        check("t6_aw", 64'(aw_hs - b_aw), 64'd0);
        check("t6_ar", 64'(ar_hs - b_ar), 64'd1);
        check("t6_err", 64'(err_count), 64'h0);

        // Reset while waiting in RD_DATA
        load_op(2'd0, 2'b10, 4'hC, 32'h5A, 32'hFF);
        r_hold = 1'b1;
        start_seq(3'd1, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rready) begin ok = 1'b1; break; end
            @(posedge clk); #2;
        end
        check("t7_in_rd_data", 64'(ok), 64'h1);
        rst = 1'b1;
        @(posedge clk); #2;
        check("t7_rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, busy, done, timeout}), 64'h0);
        check("t7_rst_err", 64'(err_count), 64'h0);
        check("t7_rst_rdata", 64'(last_rdata), 64'h0);
        rst = 1'b0; r_hold = 1'b0;
        @(posedge clk); #2;

        // Error responses
        load_op(2'd0, 2'b01, 4'h4, 32'hA5, 32'h0);
        bresp_cfg = 2'b10;
        run_seq(3'd1, 8'd1, "t8_done");
        bresp_cfg = 2'b00;
        load_op(2'd0, 2'b10, 4'h4, 32'h00, 32'hFF);
        rresp_cfg = 2'b10;
`ifdef I2C_AXIL_SEQ_RESP_CHECK_EN
        check("t8_bresp_err", 64'(err_count), 64'd1);
        run_seq(3'd1, 8'd1, "t9_done");
        check("t9_rresp_mismatch_err", 64'(err_count), 64'd2);
`else
        check("t8_bresp_ignored", 64'(err_count), 64'd0);
        run_seq(3'd1, 8'd1, "t9_done");
        check("t9_rresp_ignored", 64'(err_count), 64'd1);
`endif
        rresp_cfg = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_axil_test_seq.md
Name: i2c_axil_test_seq

Overview:
- Parametrised AXI-lite master sequencer for hardware bring-up of the I2C master's AXI-lite register slave.
- Replaces tie-off style test tops with a programmable op list: register writes, reads with masked compare, and polls with a retry limit.
- Runs the op list LOOPS times and reports an error count and the last read data.
- Sits between a loader (VIO, UART bridge or bench) and the I2C master's s_axil_* port.

Parameters:
- ADDR_WIDTH, 4, AXI-lite address width.
- DATA_WIDTH, 32, AXI-lite data width; strobe width is DATA_WIDTH/8.
- NUM_OPS, 16, op memory depth; must be >=2 and a power of two.
- POLL_MAX, 1024, maximum read attempts per POLL op before declaring a timeout.
- ERR_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; ignored while busy.
- loops  in  8  pass count, sampled on start; 0 is treated as 1.
- op_we  in  1  op memory write enable; ignored while busy.
- op_waddr  in  $clog2(NUM_OPS)  op memory write address.
- op_wdata  in  2+ADDR_WIDTH+2*DATA_WIDTH  op word {type[1:0], addr, data, mask}.
- op_count  in  $clog2(NUM_OPS)+1  number of valid ops (1..NUM_OPS), sampled on start.
- m_axil_aw*/w*/b*/ar*/r*  mixed  standard AXI-lite master channels; awprot and arprot are 3'b000; wstrb is all ones.
- busy  out  1  high from the cycle after start until done.
- done  out  1  single-cycle pulse at completion.
- err_count  out  ERR_WIDTH  saturating error count; cleared on start.
- timeout  out  1  sticky; set by any POLL timeout; cleared on start.
- last_rdata  out  DATA_WIDTH  data of the most recent R beat.

Behaviour:
- Reset values: all valid/ready outputs 0, busy 0, done 0, err_count 0, timeout 0, last_rdata 0. State returns to IDLE. Op memory contents are not reset.
- Op types:
  - 00 NOP.
  - 01 WRITE: write data to addr.
  - 10 READ: read addr; error if ((rdata ^ data) & mask) != 0.
  - 11 POLL: repeat read of addr until ((rdata ^ data) & mask) == 0, or POLL_MAX attempts.
- State machine: IDLE -> FETCH -> {WR_ADDR_DATA -> WR_RESP | RD_ADDR -> RD_DATA -> CHECK} -> NEXT -> FETCH, or -> DONE -> IDLE.
- FETCH: op memory read is synchronous; one cycle of latency from FETCH to the op being valid.
- WR_ADDR_DATA:
  - awvalid and wvalid are asserted together.
  - Each drops independently once its handshake completes.
  - Go to WR_RESP when both are done, including when both complete in the same cycle.
- WR_RESP: bready=1; leave on bvalid.
- RD_ADDR: arvalid until arready.
- RD_DATA: rready=1; on rvalid, capture last_rdata.
- CHECK (READ): increment err_count on mismatch. Go to NEXT.
- CHECK (POLL):
  - On match, go to NEXT.
  - Otherwise increment the attempt counter and return to RD_ADDR.
  - When attempts reach POLL_MAX: set timeout, increment err_count, go to NEXT.
- NOP: go straight to NEXT.
- NEXT:
  - If op index == op_count-1 and pass == loops-1, go to DONE.
  - Else if op index == op_count-1, set op index to 0, increment pass, go to FETCH.
  - Else increment op index and go to FETCH.
- DONE: done=1 for one cycle, busy=0 from the next cycle.
- err_count saturates at 2^ERR_WIDTH-1 and never wraps.
- Valid outputs are never withdrawn before their handshake, and AXI payloads stay stable while valid.
- start arriving in the same cycle as done is ignored; a new start is accepted from IDLE only.
- op_we while busy is dropped, so the op memory is not modified.
- rst mid-transaction aborts immediately. The slave must be reset alongside; the sequencer does not drain outstanding channels.

Optional Feature:
- Macro: I2C_AXIL_SEQ_RESP_CHECK_EN.
- Defined: any bresp or rresp != 2'b00 increments err_count, once per response beat. This is in addition to any compare error, so a bad-response mismatched read counts 2.
- Undefined: bresp and rresp are ignored.

Test Plan:
- Load WRITE 0x4 = 0x0000_00A5, then READ 0x4 data 0xA5 mask 0xFF; op_count=2, loops=1 -> one AW/W/B and one AR/R; err_count=0, last_rdata=0xA5, done pulse, busy low the next cycle.
- Slave asserts awready 3 cycles before wready, then the reverse, then both in the same cycle -> exactly one write per op and no duplicate valid after its handshake.
- POLL 0x0 data 0x0 mask 0x1; slave returns bit0=1 for 5 reads then 0 -> 6 AR transactions, timeout=0, err_count=0.
- POLL with POLL_MAX=4 and the bit never clearing -> exactly 4 reads, timeout=1, err_count=1.
- loops=3, op_count=2 with a mismatching READ -> 6 ops executed, err_count=3; a subsequent start clears err_count to 0.
- rst asserted during RD_DATA -> all outputs return to their reset values the next cycle; with I2C_AXIL_SEQ_RESP_CHECK_EN defined, bresp=2'b10 on a WRITE -> err_count=1.
